// File: rtl/timer_defs_pkg.sv
// Shared definitions for the countdown interrupt timer: FSM states, register
// offsets, CTRL bit positions and mode codes.
package timer_defs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

   localparam logic [1:0] OFS_CTRL   = 2'd0;
   localparam logic [1:0] OFS_PRESET = 2'd1;
   localparam logic [1:0] OFS_COUNT  = 2'd2;
   localparam logic [1:0] OFS_PSC    = 2'd3;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM       = 3;

   localparam logic [1:0] MODE_ONESHOT  = 2'd0;
   localparam logic [1:0] MODE_PERIODIC = 2'd1;

   localparam int PSC_W = 16;

   // Field order matches the CTRL bit positions so the struct reads back as-is.
   typedef struct packed {
      logic       im;
      logic [1:0] mode;
      logic       en;
   } ctrl_t;

endpackage

// File: rtl/timer_prescaler.sv
// Count divider for the timer: tick is high when the divider equals PSC.
// Exists only when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler
   import timer_defs_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             run,
   input  logic [PSC_W-1:0] psc,
   output logic             tick
);

   logic [PSC_W-1:0] div_q, div_d;

   assign tick = (div_q == psc);

   always_comb begin
      div_d = div_q;
      if (clr) begin
         div_d = '0;
      end else if (run) begin
         div_d = tick ? '0 : div_q + PSC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule
`endif

// File: rtl/timer_irq_src.sv
// Memory-mapped countdown timer driving one external interrupt line.
// Define TIMER_PRESCALE_EN to add the PSC register and count divider.
module timer_irq_src
   import timer_defs_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        wen,
   input  logic [31:0] wdat,
   output logic [31:0] rdat,
   output logic        irq
);

   state_e           state_q, state_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic [CNT_W-1:0] preset_q, preset_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             irq_pend_q, irq_pend_d;
   logic             irq_q, irq_d;

   logic [1:0] ofs;
   logic       wr_ctrl, wr_preset;
   logic       pend_set, pend_clr, fsm_en_clr;
   logic       cnt_tick;
   logic       unused_bus;

   assign ofs        = addr[3:2];
   assign wr_ctrl    = wen && (ofs == OFS_CTRL);
   assign wr_preset  = wen && (ofs == OFS_PRESET);
   assign unused_bus = ^{addr[31:4], addr[1:0], wdat};
   assign irq        = irq_q;

`ifdef TIMER_PRESCALE_EN
   logic [PSC_W-1:0] psc_q, psc_d;

   assign psc_d = (wen && (ofs == OFS_PSC)) ? wdat[PSC_W-1:0] : psc_q;

   timer_prescaler u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_q == ST_LOAD),
      .run  ((state_q == ST_CNT) && ctrl_q.en),
      .psc  (psc_q),
      .tick (cnt_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         psc_q <= '0;
      end else begin
         psc_q <= psc_d;
      end
   end
`else
   assign cnt_tick = 1'b1;
`endif

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path can infer a latch.
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      pend_set   = 1'b0;
      pend_clr   = 1'b0;
      fsm_en_clr = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ctrl_q.en) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_q.en) begin
               state_d = ST_IDLE;
            end else if (cnt_tick) begin
               // Expiry at 1 (not 0) is what makes PRESET=0 time like PRESET=1.
               if (count_q <= CNT_W'(1)) begin
                  count_d  = '0;
                  pend_set = 1'b1;
                  state_d  = ST_INT;
               end else begin
                  count_d = count_q - CNT_W'(1);
               end
            end
         end
         default: begin
            if (ctrl_q.mode == MODE_PERIODIC) begin
               pend_clr = 1'b1;
               state_d  = ST_LOAD;
            end else begin
               fsm_en_clr = 1'b1;
               state_d    = ST_IDLE;
            end
         end
      endcase

      // Bus write to CTRL overrides the hardware en clear on the same edge.
      if (fsm_en_clr) ctrl_d.en = 1'b0;
      if (wr_ctrl) begin
         ctrl_d.en   = wdat[CTRL_EN];
         ctrl_d.mode = wdat[CTRL_MODE_MSB:CTRL_MODE_LSB];
         ctrl_d.im   = wdat[CTRL_IM];
      end
      if (wr_preset) preset_d = wdat[CNT_W-1:0];

      // Set is applied last so an expiry is never lost to a concurrent ack.
      irq_pend_d = irq_pend_q;
      if (pend_clr || wr_ctrl || wr_preset) irq_pend_d = 1'b0;
      if (pend_set) irq_pend_d = 1'b1;

      irq_d = irq_pend_d & ctrl_d.im;
   end

   always_comb begin
      rdat = 32'h0;
      case (ofs)
         OFS_CTRL:   rdat = {28'h0, ctrl_q};
         OFS_PRESET: rdat = 32'(preset_q);
         OFS_COUNT:  rdat = 32'(count_q);
`ifdef TIMER_PRESCALE_EN
         default:    rdat = 32'(psc_q);
`else
         default:    rdat = 32'h0;
`endif
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
      if (rst) begin
         state_q    <= ST_IDLE;
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         irq_pend_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_pend_q <= irq_pend_d;
         irq_q      <= irq_d;
      end
   end

endmodule
